// File: rtl/fifo_pkg.sv
// Shared widths and sizing helpers for the FIFO drain stage.
package fifo_pkg;
  localparam int FIFO_WIDTH    = 16;
  localparam int DEF_BUF_DEPTH = 4;

  typedef logic [FIFO_WIDTH-1:0] word_t;

  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Occupancy must be able to represent a completely full buffer.
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/fifo_out_buf.sv
// Circular output buffer: push at tail, pop at head, head word always presented.
module fifo_out_buf
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = DEF_BUF_DEPTH,
  localparam int PW   = ptr_w(DEPTH),
  localparam int OW   = occ_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [OW-1:0]    occ,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= ptr_inc(tail);
      end
      if (pop) head <= ptr_inc(head);
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  assign head_data = mem[head];

  // Pop issue reserves a slot before the word lands, so this can never trip.
  assert property (@(posedge clk) disable iff (!rst_) occ <= OW'(DEPTH));

endmodule

// File: rtl/fifo_stream_out.sv
// FIFO drain stage: pops the upstream FIFO, buffers words, re-presents them on valid/ready.
module fifo_stream_out
  import fifo_pkg::*;
#(
  parameter int WIDTH     = FIFO_WIDTH,
  parameter int BUF_DEPTH = DEF_BUF_DEPTH,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             fifo_empty,
  input  logic             fifo_write,
  input  logic [WIDTH-1:0] fifo_data_out,
  output logic             fifo_read,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] words_out
);

  localparam int OW = occ_w(BUF_DEPTH);
  localparam logic [OW:0] DEPTH_V = (OW + 1)'(BUF_DEPTH);

  logic          inflight;
  logic [OW-1:0] occ;
  logic [OW:0]   pending;
  logic          xfer;

  // Credit counts the word still in flight; a same-cycle stream pop is ignored
  // so m_ready never reaches fifo_read combinationally.
  assign pending   = {1'b0, occ} + {{OW{1'b0}}, inflight};
  assign fifo_read = rst_ && !fifo_empty && !fifo_write && (pending < DEPTH_V);

  assign m_valid = (occ != '0);
  assign xfer    = m_valid && m_ready;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      inflight  <= 1'b0;
      words_out <= '0;
    end else begin
      inflight <= fifo_read;
      if (xfer) words_out <= words_out + 1'b1;
    end
  end

  fifo_out_buf #(
    .WIDTH (WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_      (rst_),
    .push      (inflight),
    .push_data (fifo_data_out),
    .pop       (xfer),
    .occ       (occ),
    .head_data (m_data)
  );

endmodule

// File: doc/fifo_stream_out.md
Name: fifo_stream_out

Overview:
- Downstream drain stage for the FIFO block.
- Watches fifo_empty, issues fifo_read pops, and captures fifo_data_out one cycle after each accepted pop.
- Re-presents captured words on a valid/ready stream to the next consumer.
- Holds captured words in a small output buffer, so back-pressure never loses a popped word.

Parameters:
- WIDTH, 16, data word width; must match the FIFO data width.
- BUF_DEPTH, 4, output buffer entries; minimum 2; 3 or more is required for one word per cycle.
- CNT_W, 16, width of the delivered-word counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_  in  1  asynchronous active-low reset.
- fifo_empty  in  1  upstream FIFO empty flag.
- fifo_write  in  1  upstream FIFO write strobe (monitor only); a write in the same cycle blocks the FIFO's read.
- fifo_data_out  in  WIDTH  upstream FIFO registered read data.
- fifo_read  out  1  pop request to the FIFO.
- m_data  out  WIDTH  stream data, head of the output buffer.
- m_valid  out  1  stream data valid.
- m_ready  in  1  consumer ready.
- words_out  out  CNT_W  count of words delivered on the stream.

Behaviour:
- Reset (rst_ low, asynchronous):
  - occupancy, pointers, inflight flag and words_out all clear to 0.
  - m_valid = 0, m_data = 0, fifo_read = 0.
  - A pop in flight when reset asserts is discarded.
- fifo_read is combinational: !fifo_empty && !fifo_write && (occ + inflight < BUF_DEPTH).
  - No combinational path from m_ready to fifo_read; a same-cycle stream pop is not credited.
- Accepted pop: fifo_read high at a rising edge. Set inflight = 1 at that edge.
- Capture: at the next edge, if inflight = 1, write fifo_data_out into the buffer tail and increment occ.
  - inflight is re-set if another pop is accepted at the same edge, else cleared.
- Stream output:
  - m_valid = (occ != 0); m_data = buffer head.
  - Both are registered, with no combinational path from any input.
- Transfer: m_valid && m_ready at an edge pops the head and increments words_out.
  - words_out wraps modulo 2^CNT_W.
- Simultaneous capture and transfer at the same edge: occ unchanged, head and tail pointers both advance.
- Pointer wrap: head and tail wrap to 0 after BUF_DEPTH-1.
- Stall hold: while m_valid && !m_ready, m_data and m_valid must stay stable.
- Full buffer:
  - fifo_read stays low while occ + inflight == BUF_DEPTH.
  - Overflow is impossible by construction; assert occ <= BUF_DEPTH.
- Empty upstream: fifo_read stays low; no spurious capture occurs.
- Latency: FIFO non-empty to m_valid is 2 cycles (pop edge, capture edge, then visible).
- Throughput: with BUF_DEPTH >= 3 and m_ready held high, one word per cycle is sustained.

Decomposition:
- Package fifo_pkg holds:
  - the FIFO_WIDTH default (16);
  - the BUF_DEPTH default;
  - the occupancy/pointer width function ($clog2-based);
  - a typedef for the data word.
- One sub-module, fifo_out_buf: the circular output buffer (push, pop, occ, head data).
- The top level holds the pop-issue logic, the inflight flag and the counter.

Test Plan:
- Reset, then FIFO empty for 10 cycles -> fifo_read = 0, m_valid = 0, words_out = 0 throughout.
- FIFO loaded with 0x1111, 0x2222, 0x3333, m_ready = 1:
  - first m_valid exactly 2 cycles after the first fifo_read;
  - stream order 0x1111, 0x2222, 0x3333;
  - words_out = 3.
- 8 words queued, m_ready = 0:
  - fifo_read stops after 4 pops; occ = 4; m_data holds the first word stable;
  - release m_ready -> all 8 words out in order, no loss or duplication.
- fifo_write high in the same cycle as fifo_empty = 0 -> fifo_read = 0 that cycle; no capture on the next edge.
- Sustained 20-word transfer with m_ready = 1 -> 20 consecutive cycles of m_valid after fill; words_out = 20.
- rst_ asserted asynchronously mid-stream with inflight = 1:
  - m_valid drops immediately; words_out = 0;
  - after release, the next FIFO word is delivered with no stale word.
